dma_mem_arbiter: RTL and testbench

- Shares the single DMA-to-memory-controller port between NUM_REQ stream DMA requesters.
- Read and write channels are arbitrated independently, each round-robin.
- Issued reads are tracked in an in-order tag FIFO, so read data returning from the memory controller is steered back to the requester that issued it.
- Sits between the per-stream DMA engines and the memory access controller inside each PE.

---
 rtl/dma_mem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_dma_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_arbiter.sv
// Shares one memory-controller port between NUM_REQ DMA requesters, with independent round-robin read/write
// arbitration and in-order read-tag return. Define DMA_MEM_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority.
module dma_mem_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 64,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             reset_poweron,
   input  logic [NUM_REQ-1:0]               req__arb__read_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req__arb__read_address,
   output logic [NUM_REQ-1:0]               arb__req__read_ready,
   input  logic [NUM_REQ-1:0]               req__arb__read_pause,
   output logic [DATA_WIDTH-1:0]            arb__req__read_data,
   output logic [NUM_REQ-1:0]               arb__req__read_data_valid,
   input  logic [NUM_REQ-1:0]               req__arb__write_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req__arb__write_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req__arb__write_data,
   output logic [NUM_REQ-1:0]               arb__req__write_ready,
   output logic                             arb__memc__read_valid,
   output logic [ADDR_WIDTH-1:0]            arb__memc__read_address,
   input  logic                             memc__arb__read_ready,
   input  logic [DATA_WIDTH-1:0]            memc__arb__read_data,
   input  logic                             memc__arb__read_data_valid,
   output logic                             arb__memc__read_pause,
   output logic                             arb__memc__write_valid,
   output logic [ADDR_WIDTH-1:0]            arb__memc__write_address,
   output logic [DATA_WIDTH-1:0]            arb__memc__write_data,
   input  logic                             memc__arb__write_ready,
   output logic                             arb__sys__error
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TPTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int TCNT_W = $clog2(TAG_DEPTH + 1);
   localparam logic [TCNT_W-1:0] TAG_FULL = TCNT_W'(TAG_DEPTH);

   typedef enum logic [0:0] {CMD_EMPTY = 1'b0, CMD_HOLD = 1'b1} cmd_state_t;

   // Returns {found, index} of the first valid requester at or after start, wrapping.
   function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] valid, input logic [IDX_W-1:0] start);
      logic             found;
      logic [IDX_W-1:0] idx;
      int               cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(start) + k) % NUM_REQ;
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = IDX_W'(cand);
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   cmd_state_t              rd_state_r, rd_state_s, wr_state_r, wr_state_s;
   logic [ADDR_WIDTH-1:0]   rd_addr_r, wr_addr_r;
   logic [DATA_WIDTH-1:0]   wr_data_r;
   logic [IDX_W-1:0]        rd_start_s, wr_start_s, rd_win_s, wr_win_s;
   logic                    rd_found_s, wr_found_s;
   logic                    rd_free_s, wr_free_s, rd_accept_s, wr_accept_s;
   logic [IDX_W-1:0]        tag_mem_r [TAG_DEPTH];
   logic [TPTR_W-1:0]       tag_wr_r, tag_rd_r;
   logic [TCNT_W-1:0]       tag_cnt_r;
   logic                    tag_empty_s, tag_full_s, tag_pop_s;
   logic [IDX_W-1:0]        tag_head_s;
   logic                    error_r;

`ifdef DMA_MEM_ARB_STRICT_PRIO_EN
   assign rd_start_s = '0;
   assign wr_start_s = '0;
`else
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   logic [IDX_W-1:0] rd_ptr_r, wr_ptr_r;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] ptr);
      return (ptr == LAST_IDX) ? IDX_W'(0) : ptr + 1'b1;
   endfunction

   assign rd_start_s = next_idx(rd_ptr_r);
   assign wr_start_s = next_idx(wr_ptr_r);

   // Round-robin pointers remember the last accepted winner of each channel.
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         rd_ptr_r <= LAST_IDX;
         wr_ptr_r <= LAST_IDX;
      end else begin
         rd_ptr_r <= rd_accept_s ? rd_win_s : rd_ptr_r;
         wr_ptr_r <= wr_accept_s ? wr_win_s : wr_ptr_r;
      end
   end
`endif

   assign {rd_found_s, rd_win_s} = pick(req__arb__read_valid, rd_start_s);
   assign {wr_found_s, wr_win_s} = pick(req__arb__write_valid, wr_start_s);

   assign tag_empty_s = (tag_cnt_r == TCNT_W'(0));
   assign tag_full_s  = (tag_cnt_r == TAG_FULL);
   assign tag_pop_s   = memc__arb__read_data_valid && !tag_empty_s;
   assign tag_head_s  = tag_mem_r[tag_rd_r];

   assign rd_free_s   = (rd_state_r == CMD_EMPTY) || memc__arb__read_ready;
   assign wr_free_s   = (wr_state_r == CMD_EMPTY) || memc__arb__write_ready;
   // A full tag FIFO still takes a read when a return pops the head in the same cycle.
   assign rd_accept_s = !reset_poweron && rd_found_s && rd_free_s && (!tag_full_s || tag_pop_s);
   assign wr_accept_s = !reset_poweron && wr_found_s && wr_free_s;

   // Command-stage state registers for both channels.
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         rd_state_r <= CMD_EMPTY;
         wr_state_r <= CMD_EMPTY;
      end else begin
         rd_state_r <= rd_state_s;
         wr_state_r <= wr_state_s;
      end
   end

   // Next-state logic: a held command drains on memc ready unless a new one replaces it.
   always_comb begin
      rd_state_s = rd_state_r;
      wr_state_s = wr_state_r;
      case (rd_state_r)
         CMD_EMPTY: rd_state_s = rd_accept_s ? CMD_HOLD : CMD_EMPTY;
         CMD_HOLD:  rd_state_s = (rd_accept_s || !memc__arb__read_ready) ? CMD_HOLD : CMD_EMPTY;
         default:   rd_state_s = CMD_EMPTY;
      endcase
      case (wr_state_r)
         CMD_EMPTY: wr_state_s = wr_accept_s ? CMD_HOLD : CMD_EMPTY;
         CMD_HOLD:  wr_state_s = (wr_accept_s || !memc__arb__write_ready) ? CMD_HOLD : CMD_EMPTY;
         default:   wr_state_s = CMD_EMPTY;
      endcase
   end

   // Command payload registers load the winner's address and data on acceptance.
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         rd_addr_r <= '0;
         wr_addr_r <= '0;
         wr_data_r <= '0;
      end else begin
         if (rd_accept_s) begin
            rd_addr_r <= req__arb__read_address[int'(rd_win_s)*ADDR_WIDTH +: ADDR_WIDTH];
         end else begin
            rd_addr_r <= rd_addr_r;
         end
         if (wr_accept_s) begin
            wr_addr_r <= req__arb__write_address[int'(wr_win_s)*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_r <= req__arb__write_data[int'(wr_win_s)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
         end
      end
   end

   // Tag storage holds requester indices of outstanding reads, oldest at tag_rd_r.
   always_ff @(posedge clk) begin
      if (rd_accept_s) begin
         tag_mem_r[tag_wr_r] <= rd_win_s;
      end else begin
         tag_mem_r[tag_wr_r] <= tag_mem_r[tag_wr_r];
      end
   end

   // Tag FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         tag_wr_r  <= '0;
         tag_rd_r  <= '0;
         tag_cnt_r <= '0;
      end else begin
         tag_wr_r <= rd_accept_s ? tag_wr_r + 1'b1 : tag_wr_r;
         tag_rd_r <= tag_pop_s ? tag_rd_r + 1'b1 : tag_rd_r;
         case ({rd_accept_s, tag_pop_s})
            2'b10:   tag_cnt_r <= tag_cnt_r + 1'b1;
            2'b01:   tag_cnt_r <= tag_cnt_r - 1'b1;
            default: tag_cnt_r <= tag_cnt_r;
         endcase
      end
   end

   // Sticky error on returned data with no outstanding read.
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         error_r <= 1'b0;
      end else if (memc__arb__read_data_valid && tag_empty_s) begin
         error_r <= 1'b1;
      end else begin
         error_r <= error_r;
      end
   end

   // Read-channel outputs: command decode, grant strobe and return steering.
   always_comb begin
      arb__req__read_ready      = '0;
      arb__req__read_data_valid = '0;
      arb__memc__read_pause     = 1'b0;
      arb__memc__read_valid     = (rd_state_r == CMD_HOLD);
      arb__memc__read_address   = rd_addr_r;
      arb__req__read_data       = memc__arb__read_data;
      if (rd_accept_s) begin
         arb__req__read_ready[rd_win_s] = 1'b1;
      end else begin
         arb__req__read_ready = '0;
      end
      if (tag_pop_s) begin
         arb__req__read_data_valid[tag_head_s] = 1'b1;
      end else begin
         arb__req__read_data_valid = '0;
      end
      if (!tag_empty_s) begin
         arb__memc__read_pause = req__arb__read_pause[tag_head_s];
      end else begin
         arb__memc__read_pause = 1'b0;
      end
   end

   // Write-channel outputs and error flag.
   always_comb begin
      arb__req__write_ready    = '0;
      arb__memc__write_valid   = (wr_state_r == CMD_HOLD);
      arb__memc__write_address = wr_addr_r;
      arb__memc__write_data    = wr_data_r;
      arb__sys__error          = error_r;
      if (wr_accept_s) begin
         arb__req__write_ready[wr_win_s] = 1'b1;
      end else begin
         arb__req__write_ready = '0;
      end
   end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Randomized and directed self-checking bench for dma_mem_arbiter against a queue-based reference model.
module tb_dma_mem_arbiter;
   localparam int N = 2, AW = 24, DW = 64, TD = 4;
`ifdef DMA_MEM_ARB_STRICT_PRIO_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_poweron;
   logic [N-1:0] req__arb__read_valid, arb__req__read_ready, req__arb__read_pause, arb__req__read_data_valid;
   logic [N*AW-1:0] req__arb__read_address, req__arb__write_address;
   logic [DW-1:0] arb__req__read_data, memc__arb__read_data, arb__memc__write_data;
   logic [N-1:0] req__arb__write_valid, arb__req__write_ready;
   logic [N*DW-1:0] req__arb__write_data;
   logic arb__memc__read_valid, memc__arb__read_ready, memc__arb__read_data_valid, arb__memc__read_pause;
   logic arb__memc__write_valid, memc__arb__write_ready, arb__sys__error;
   logic [AW-1:0] arb__memc__read_address, arb__memc__write_address;

   int errors = 0;
   int checks = 0;

   int m_rd_last, m_wr_last;
   bit m_rd_hold, m_wr_hold, m_err;
   logic [AW-1:0] m_rd_addr, m_wr_addr;
   logic [DW-1:0] m_wr_data;
   int m_tags[$];

   always #5 clk = ~clk;

   dma_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .reset_poweron(reset_poweron),
      .req__arb__read_valid(req__arb__read_valid), .req__arb__read_address(req__arb__read_address),
      .arb__req__read_ready(arb__req__read_ready), .req__arb__read_pause(req__arb__read_pause),
      .arb__req__read_data(arb__req__read_data), .arb__req__read_data_valid(arb__req__read_data_valid),
      .req__arb__write_valid(req__arb__write_valid), .req__arb__write_address(req__arb__write_address),
      .req__arb__write_data(req__arb__write_data), .arb__req__write_ready(arb__req__write_ready),
      .arb__memc__read_valid(arb__memc__read_valid), .arb__memc__read_address(arb__memc__read_address),
      .memc__arb__read_ready(memc__arb__read_ready), .memc__arb__read_data(memc__arb__read_data),
      .memc__arb__read_data_valid(memc__arb__read_data_valid), .arb__memc__read_pause(arb__memc__read_pause),
      .arb__memc__write_valid(arb__memc__write_valid), .arb__memc__write_address(arb__memc__write_address),
      .arb__memc__write_data(arb__memc__write_data), .memc__arb__write_ready(memc__arb__write_ready),
      .arb__sys__error(arb__sys__error)
   );

   // Winner by the arbitration rule: first valid after the last winner, or lowest index when strict.
   function automatic int pick_model(input logic [N-1:0] v, input int last);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = STRICT ? (k - 1) : ((last + k) % N);
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      req__arb__read_valid = '0; req__arb__read_address = '0; req__arb__read_pause = '0;
      req__arb__write_valid = '0; req__arb__write_address = '0; req__arb__write_data = '0;
      memc__arb__read_ready = 1'b0; memc__arb__read_data = '0; memc__arb__read_data_valid = 1'b0;
      memc__arb__write_ready = 1'b0;
   endtask

   task automatic do_reset;
      reset_poweron = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset_poweron = 1'b0;
   endtask

   task automatic test_reset;
      reset_poweron = 1'b1;
      clear_inputs();
      req__arb__read_valid = 2'b11; req__arb__write_valid = 2'b11;
      req__arb__read_address = {24'h000123, 24'h000456};
      repeat (2) @(posedge clk);
      #1;
      checks++; if (arb__req__read_ready !== 2'b00) begin errors++; $display("FAIL reset_read_ready got=%b want=00", arb__req__read_ready); end
      checks++; if (arb__req__write_ready !== 2'b00) begin errors++; $display("FAIL reset_write_ready got=%b want=00", arb__req__write_ready); end
      checks++; if (arb__memc__read_valid !== 1'b0) begin errors++; $display("FAIL reset_memc_read_valid got=%b want=0", arb__memc__read_valid); end
      checks++; if (arb__memc__write_valid !== 1'b0) begin errors++; $display("FAIL reset_memc_write_valid got=%b want=0", arb__memc__write_valid); end
      checks++; if (arb__memc__read_address !== 24'h0) begin errors++; $display("FAIL reset_read_address got=%h want=0", arb__memc__read_address); end
      checks++; if (arb__memc__write_data !== 64'h0) begin errors++; $display("FAIL reset_write_data got=%h want=0", arb__memc__write_data); end
      checks++; if (arb__sys__error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", arb__sys__error); end
      checks++; if (arb__req__read_data_valid !== 2'b00 || arb__memc__read_pause !== 1'b0) begin errors++; $display("FAIL reset_return got=%b/%b want=00/0", arb__req__read_data_valid, arb__memc__read_pause); end
      reset_poweron = 1'b0;
      clear_inputs();
   endtask

   task automatic test_rr_reads;
      do_reset();
      req__arb__read_valid = 2'b11;
      req__arb__read_address = {24'h000101, 24'h000100};
      memc__arb__read_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         memc__arb__read_data_valid = (k >= 1);
         memc__arb__read_data = {$urandom, $urandom};
         #1;
         checks++; if (arb__req__read_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_read_ready cyc=%0d got=%b", k, arb__req__read_ready); end
         if (k == 0) begin
            checks++; if (arb__memc__read_valid !== 1'b0) begin errors++; $display("FAIL rr_latency got=%b want=0", arb__memc__read_valid); end
         end else begin
            checks++; if (arb__req__read_data_valid !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_return cyc=%0d got=%b", k, arb__req__read_data_valid); end
         end
         tick();
         checks++; if (arb__memc__read_valid !== 1'b1 || arb__memc__read_address !== 24'h100 + 24'(k % 2)) begin errors++; $display("FAIL rr_memc_addr cyc=%0d got=%b/%h want=1/%h", k, arb__memc__read_valid, arb__memc__read_address, 24'h100 + 24'(k % 2)); end
      end
      clear_inputs();
   endtask

   task automatic test_fifo_full;
      do_reset();
      memc__arb__read_ready = 1'b1;
      req__arb__read_valid = 2'b10;
      for (int k = 0; k < 5; k++) begin
         req__arb__read_address = {24'h10 + 24'(k), 24'h0};
         #1;
         checks++; if (arb__req__read_ready !== ((k < 4) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL full_read_ready n=%0d got=%b", k, arb__req__read_ready); end
         tick();
         if (k < 4) begin
            checks++; if (arb__memc__read_address !== 24'h10 + 24'(k)) begin errors++; $display("FAIL full_memc_addr n=%0d got=%h want=%h", k, arb__memc__read_address, 24'h10 + 24'(k)); end
         end else begin
            checks++; if (arb__memc__read_valid !== 1'b0) begin errors++; $display("FAIL full_no_cmd got=%b want=0", arb__memc__read_valid); end
         end
      end
      req__arb__read_valid = 2'b00;
      for (int k = 0; k < 4; k++) begin
         memc__arb__read_data_valid = 1'b1;
         memc__arb__read_data = 64'hD000 + 64'(k);
         #1;
         checks++; if (arb__req__read_data_valid !== 2'b10 || arb__req__read_data !== 64'hD000 + 64'(k)) begin errors++; $display("FAIL full_return n=%0d got=%b/%h", k, arb__req__read_data_valid, arb__req__read_data); end
         tick();
      end
      memc__arb__read_data_valid = 1'b0;
      checks++; if (arb__sys__error !== 1'b0) begin errors++; $display("FAIL full_no_error got=%b want=0", arb__sys__error); end
      clear_inputs();
   endtask

   task automatic test_read_routing;
      do_reset();
      memc__arb__read_ready = 1'b1;
      req__arb__read_valid = 2'b01; req__arb__read_address = {24'h21, 24'h20};
      tick();
      req__arb__read_valid = 2'b10;
      tick();
      req__arb__read_valid = 2'b00;
      req__arb__read_pause = 2'b01;
      #1;
      checks++; if (arb__memc__read_pause !== 1'b1) begin errors++; $display("FAIL route_pause_head0 got=%b want=1", arb__memc__read_pause); end
      req__arb__read_pause = 2'b10;
      #1;
      checks++; if (arb__memc__read_pause !== 1'b0) begin errors++; $display("FAIL route_pause_other got=%b want=0", arb__memc__read_pause); end
      req__arb__read_pause = 2'b00;
      memc__arb__read_data_valid = 1'b1; memc__arb__read_data = 64'hD0;
      #1;
      checks++; if (arb__req__read_data_valid !== 2'b01 || arb__req__read_data !== 64'hD0) begin errors++; $display("FAIL route_d0 got=%b/%h want=01/d0", arb__req__read_data_valid, arb__req__read_data); end
      tick();
      memc__arb__read_data = 64'hD1; req__arb__read_pause = 2'b10;
      #1;
      checks++; if (arb__req__read_data_valid !== 2'b10 || arb__memc__read_pause !== 1'b1) begin errors++; $display("FAIL route_d1 got=%b/%b want=10/1", arb__req__read_data_valid, arb__memc__read_pause); end
      tick();
      memc__arb__read_data_valid = 1'b0;
      #1;
      checks++; if (arb__memc__read_pause !== 1'b0) begin errors++; $display("FAIL route_pause_empty got=%b want=0", arb__memc__read_pause); end
      clear_inputs();
   endtask

   task automatic test_write_hold;
      logic [1:0]  exp_rdy;
      logic [23:0] exp_addr;
      do_reset();
      req__arb__write_valid = 2'b01;
      req__arb__write_address = {24'h50, 24'h30};
      req__arb__write_data = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444};
      #1;
      checks++; if (arb__req__write_ready !== 2'b01) begin errors++; $display("FAIL wr_first_ready got=%b want=01", arb__req__write_ready); end
      tick();
      for (int k = 0; k < 3; k++) begin
         req__arb__write_valid = 2'b11;
         req__arb__write_address = {24'h51 + 24'(k), 24'h31 + 24'(k)};
         req__arb__write_data = {$urandom, $urandom, $urandom, $urandom};
         req__arb__read_valid = (k == 0) ? 2'b01 : 2'b00;
         memc__arb__read_ready = 1'b1;
         #1;
         checks++; if (arb__req__write_ready !== 2'b00) begin errors++; $display("FAIL wr_hold_ready cyc=%0d got=%b want=00", k, arb__req__write_ready); end
         if (k == 0) begin
            checks++; if (arb__req__read_ready !== 2'b01) begin errors++; $display("FAIL wr_hold_read_indep got=%b want=01", arb__req__read_ready); end
         end
         tick();
         checks++; if (arb__memc__write_valid !== 1'b1 || arb__memc__write_address !== 24'h30 || arb__memc__write_data !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL wr_hold_stable cyc=%0d got=%b/%h/%h", k, arb__memc__write_valid, arb__memc__write_address, arb__memc__write_data); end
      end
      req__arb__read_valid = 2'b00;
      memc__arb__write_ready = 1'b1;
      req__arb__write_address = {24'h5F, 24'h3F};
      exp_rdy = STRICT ? 2'b01 : 2'b10;
      exp_addr = STRICT ? 24'h3F : 24'h5F;
      #1;
      checks++; if (arb__req__write_ready !== exp_rdy) begin errors++; $display("FAIL wr_release_ready got=%b want=%b", arb__req__write_ready, exp_rdy); end
      tick();
      checks++; if (arb__memc__write_valid !== 1'b1 || arb__memc__write_address !== exp_addr) begin errors++; $display("FAIL wr_release_addr got=%b/%h want=1/%h", arb__memc__write_valid, arb__memc__write_address, exp_addr); end
      clear_inputs();
   endtask

   task automatic test_error;
      do_reset();
      memc__arb__read_data_valid = 1'b1;
      #1;
      checks++; if (arb__req__read_data_valid !== 2'b00) begin errors++; $display("FAIL err_no_route got=%b want=00", arb__req__read_data_valid); end
      tick();
      memc__arb__read_data_valid = 1'b0;
      checks++; if (arb__sys__error !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", arb__sys__error); end
      repeat (3) tick();
      checks++; if (arb__sys__error !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", arb__sys__error); end
      do_reset();
      checks++; if (arb__sys__error !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b want=0", arb__sys__error); end
      req__arb__read_valid = 2'b01; req__arb__read_address = {24'h0, 24'h40};
      tick();
      req__arb__read_valid = 2'b00;
      checks++; if (arb__memc__read_valid !== 1'b1) begin errors++; $display("FAIL err_pre_hold got=%b want=1", arb__memc__read_valid); end
      reset_poweron = 1'b1;
      #1;
      checks++; if (arb__memc__read_valid !== 1'b0) begin errors++; $display("FAIL err_async_reset got=%b want=0", arb__memc__read_valid); end
      do_reset();
      memc__arb__read_data_valid = 1'b1;
      #1;
      checks++; if (arb__req__read_data_valid !== 2'b00) begin errors++; $display("FAIL err_stale_route got=%b want=00", arb__req__read_data_valid); end
      tick();
      checks++; if (arb__sys__error !== 1'b1) begin errors++; $display("FAIL err_stale_set got=%b want=1", arb__sys__error); end
      clear_inputs();
   endtask

`ifdef DMA_MEM_ARB_STRICT_PRIO_EN
   task automatic test_strict;
      do_reset();
      req__arb__write_valid = 2'b11; memc__arb__write_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (arb__req__write_ready !== 2'b01) begin errors++; $display("FAIL strict_req0 cyc=%0d got=%b want=01", k, arb__req__write_ready); end
         tick();
      end
      req__arb__write_valid = 2'b10;
      #1;
      checks++; if (arb__req__write_ready !== 2'b10) begin errors++; $display("FAIL strict_req1 got=%b want=10", arb__req__write_ready); end
      tick();
      clear_inputs();
   endtask
`endif

   task automatic test_random;
      int rw, ww;
      bit rok, wok, pop;
      logic [N-1:0] e_rr, e_wr, e_dv;
      logic e_p;
      do_reset();
      m_rd_last = N - 1; m_wr_last = N - 1; m_rd_hold = 0; m_wr_hold = 0; m_err = 0;
      m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0; m_tags.delete();
      for (int c = 0; c < 400; c++) begin
         req__arb__read_valid = N'($urandom_range(0, 3));
         req__arb__write_valid = N'($urandom_range(0, 3));
         for (int i = 0; i < N; i++) begin
            req__arb__read_address[i*AW +: AW] = AW'($urandom);
            req__arb__write_address[i*AW +: AW] = AW'($urandom);
            req__arb__write_data[i*DW +: DW] = {$urandom, $urandom};
         end
         req__arb__read_pause = N'($urandom_range(0, 3));
         memc__arb__read_ready = ($urandom_range(0, 3) != 0);
         memc__arb__write_ready = ($urandom_range(0, 3) != 0);
         memc__arb__read_data_valid = (m_tags.size() > 0) && ($urandom_range(0, 2) != 0);
         memc__arb__read_data = {$urandom, $urandom};
         #1;
         pop = memc__arb__read_data_valid && (m_tags.size() > 0);
         rw = pick_model(req__arb__read_valid, m_rd_last);
         ww = pick_model(req__arb__write_valid, m_wr_last);
         rok = (rw >= 0) && (!m_rd_hold || memc__arb__read_ready) && ((m_tags.size() < TD) || pop);
         wok = (ww >= 0) && (!m_wr_hold || memc__arb__write_ready);
         e_rr = rok ? N'(1 << rw) : '0;
         e_wr = wok ? N'(1 << ww) : '0;
         e_dv = '0; e_p = 1'b0;
         if (m_tags.size() > 0) begin
            e_p = req__arb__read_pause[m_tags[0]];
            if (pop) e_dv = N'(1 << m_tags[0]);
         end
         checks++; if (arb__req__read_ready !== e_rr) begin errors++; $display("FAIL rnd_read_ready cyc=%0d got=%b want=%b", c, arb__req__read_ready, e_rr); end
         checks++; if (arb__req__write_ready !== e_wr) begin errors++; $display("FAIL rnd_write_ready cyc=%0d got=%b want=%b", c, arb__req__write_ready, e_wr); end
         checks++; if (arb__req__read_data_valid !== e_dv) begin errors++; $display("FAIL rnd_data_valid cyc=%0d got=%b want=%b", c, arb__req__read_data_valid, e_dv); end
         checks++; if (arb__memc__read_pause !== e_p) begin errors++; $display("FAIL rnd_pause cyc=%0d got=%b want=%b", c, arb__memc__read_pause, e_p); end
         checks++; if (arb__req__read_data !== memc__arb__read_data) begin errors++; $display("FAIL rnd_read_data cyc=%0d got=%h want=%h", c, arb__req__read_data, memc__arb__read_data); end
         tick();
         if (memc__arb__read_data_valid) begin
            if (m_tags.size() > 0) void'(m_tags.pop_front());
            else m_err = 1;
         end
         if (rok) begin
            m_tags.push_back(rw); m_rd_hold = 1; m_rd_last = rw;
            m_rd_addr = req__arb__read_address[rw*AW +: AW];
         end else if (memc__arb__read_ready) m_rd_hold = 0;
         if (wok) begin
            m_wr_hold = 1; m_wr_last = ww;
            m_wr_addr = req__arb__write_address[ww*AW +: AW];
            m_wr_data = req__arb__write_data[ww*DW +: DW];
         end else if (memc__arb__write_ready) m_wr_hold = 0;
         checks++; if (arb__memc__read_valid !== m_rd_hold || arb__memc__read_address !== m_rd_addr) begin errors++; $display("FAIL rnd_memc_read cyc=%0d got=%b/%h want=%b/%h", c, arb__memc__read_valid, arb__memc__read_address, m_rd_hold, m_rd_addr); end
         checks++; if (arb__memc__write_valid !== m_wr_hold || arb__memc__write_address !== m_wr_addr || arb__memc__write_data !== m_wr_data) begin errors++; $display("FAIL rnd_memc_write cyc=%0d got=%b/%h/%h want=%b/%h/%h", c, arb__memc__write_valid, arb__memc__write_address, arb__memc__write_data, m_wr_hold, m_wr_addr, m_wr_data); end
         checks++; if (arb__sys__error !== m_err) begin errors++; $display("FAIL rnd_error cyc=%0d got=%b want=%b", c, arb__sys__error, m_err); end
      end
      clear_inputs();
   endtask

   initial begin
      reset_poweron = 1'b1;
      clear_inputs();
      test_reset();
`ifndef DMA_MEM_ARB_STRICT_PRIO_EN
      test_rr_reads();
`else
      test_strict();
`endif
      test_fifo_full();
      test_read_routing();
      test_write_hold();
      test_random();
      test_error();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
